disp_src_arbiter: RTL and testbench

Two-requester arbiter that shares the 64-bit display/IO output path between two 64-bit data sources (e.g. CPU-written display word and debug/monitor word). It owns the 2:1 source-select line, grants one requester at a time with round-robin fairness, and captures the chosen word into a registered output. A valid/ready handshake presents the word to the downstream display shifter. A programmable hold interval keeps each word on the output for a minimum time before the next arbitration.

---
 rtl/disp_src_arbiter.sv | 147 ++++++++++++++
 tb/tb_disp_src_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_src_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_src_arbiter: round-robin 2:1 source arbiter feeding a registered,      |
// | valid/ready display word with a post-transfer hold interval.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module disp_src_arbiter #(
  parameter int W           = 64,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic [W-1:0] dat_a,
  input  logic         req_b,
  input  logic [W-1:0] dat_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last_a;
  logic             w_last_a_nxt;
  logic             r_gnt_a;
  logic             w_gnt_a_nxt;
  logic             r_gnt_b;
  logic             w_gnt_b_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic [W-1:0]     r_data;
  logic [W-1:0]     w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             w_pick_a;
  logic             w_pick_b;

  // On a tie the source that did not win last time gets the output.
  assign w_pick_a = req_a & (~req_b | ~r_last_a);
  assign w_pick_b = req_b & (~req_a |  r_last_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= C_CNT_ZERO;
      r_last_a <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_sel    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_a <= w_last_a_nxt;
      r_gnt_a  <= w_gnt_a_nxt;
      r_gnt_b  <= w_gnt_b_nxt;
      r_sel    <= w_sel_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_a_nxt = r_last_a;
    w_gnt_a_nxt  = 1'b0;
    w_gnt_b_nxt  = 1'b0;
    w_sel_nxt    = r_sel;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_a) begin
          w_gnt_a_nxt  = 1'b1;
          w_sel_nxt    = 1'b1;
          w_data_nxt   = dat_a;
          w_valid_nxt  = 1'b1;
          w_last_a_nxt = 1'b1;
          w_state_nxt  = ST_SEND;
        end else if (w_pick_b) begin
          w_gnt_b_nxt  = 1'b1;
          w_sel_nxt    = 1'b0;
          w_data_nxt   = dat_b;
          w_valid_nxt  = 1'b1;
          w_last_a_nxt = 1'b0;
          w_state_nxt  = ST_SEND;
        end
      end

      ST_SEND: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          if (HOLD_CYCLES > 0) begin
            w_cnt_nxt   = C_HOLD_LOAD;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_HOLD: begin
        // Requests are deliberately not sampled until the interval expires.
        if (r_cnt <= C_CNT_ONE) begin
          w_cnt_nxt   = C_CNT_ZERO;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = C_CNT_ZERO;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign gnt_a     = r_gnt_a;
  assign gnt_b     = r_gnt_b;
  assign sel       = r_sel;
  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_disp_src_arbiter.sv
`default_nettype none
// Bench for disp_src_arbiter: directed scenarios plus randomized traffic on a
// HOLD_CYCLES=4 instance and a HOLD_CYCLES=0 instance, both checked against a model.
module tb_disp_src_arbiter;

  localparam int H0 = 4;
  localparam int H1 = 0;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ra, rb, rdy;
  logic [63:0] da [2];
  logic [63:0] db [2];
  logic [1:0]  ga, gb, sl, ov;
  logic [63:0] od [2];

  int errs;
  int checks;

  // Reference model state: one entry per instance.
  logic        m_v [2];
  logic        m_ga [2];
  logic        m_gb [2];
  logic        m_sel [2];
  logic        m_last_a [2];
  logic [63:0] m_d [2];
  int          m_hold [2];

  disp_src_arbiter #(.W(64), .HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra[0]), .dat_a(da[0]), .req_b(rb[0]), .dat_b(db[0]),
    .gnt_a(ga[0]), .gnt_b(gb[0]), .sel(sl[0]), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(rdy[0])
  );

  disp_src_arbiter #(.W(64), .HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra[1]), .dat_a(da[1]), .req_b(rb[1]), .dat_b(db[1]),
    .gnt_a(ga[1]), .gnt_b(gb[1]), .sel(sl[1]), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(rdy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %b expected %b", nm, k, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_v[k]      = 1'b0;
    m_ga[k]     = 1'b0;
    m_gb[k]     = 1'b0;
    m_sel[k]    = 1'b0;
    m_last_a[k] = 1'b0;
    m_d[k]      = 64'd0;
    m_hold[k]   = 0;
  endtask

  // One clock edge of behaviour: a word waits for the handshake, then the output
  // rests for `hold` cycles, then the next request is granted round-robin.
  task automatic model_step(input int k, input int hold);
    logic win_a;
    m_ga[k] = 1'b0;
    m_gb[k] = 1'b0;
    if (m_v[k]) begin
      if (rdy[k]) begin
        m_v[k]    = 1'b0;
        m_hold[k] = hold;
      end
    end else if (m_hold[k] > 0) begin
      m_hold[k] = m_hold[k] - 1;
    end else if (ra[k] || rb[k]) begin
      win_a       = (ra[k] && rb[k]) ? !m_last_a[k] : ra[k];
      m_ga[k]     = win_a;
      m_gb[k]     = !win_a;
      m_sel[k]    = win_a;
      m_d[k]      = win_a ? da[k] : db[k];
      m_v[k]      = 1'b1;
      m_last_a[k] = win_a;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk1("gnt_a", k, ga[k], m_ga[k]);
      chk1("gnt_b", k, gb[k], m_gb[k]);
      chk1("sel", k, sl[k], m_sel[k]);
      chk1("out_valid", k, ov[k], m_v[k]);
      chk64("out_data", k, od[k], m_d[k]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, H0);
      model_step(1, H1);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk_all_zero(input string nm, input int k);
    chk1(nm, k, ga[k], 1'b0);
    chk1(nm, k, gb[k], 1'b0);
    chk1(nm, k, sl[k], 1'b0);
    chk1(nm, k, ov[k], 1'b0);
    chk64(nm, k, od[k], 64'd0);
  endtask

  task automatic rand_drive();
    for (int k = 0; k < 2; k++) begin
      rdy[k] = ($urandom_range(0, 3) != 0);
      if (ra[k] && ga[k]) begin
        ra[k] = ($urandom_range(0, 3) == 0);
        da[k] = {$urandom, $urandom};
      end else if (!ra[k]) begin
        ra[k] = ($urandom_range(0, 2) == 0);
        da[k] = {$urandom, $urandom};
      end else if ($urandom_range(0, 40) == 0) begin
        ra[k] = 1'b0;
      end
      if (rb[k] && gb[k]) begin
        rb[k] = ($urandom_range(0, 3) == 0);
        db[k] = {$urandom, $urandom};
      end else if (!rb[k]) begin
        rb[k] = ($urandom_range(0, 2) == 0);
        db[k] = {$urandom, $urandom};
      end else if ($urandom_range(0, 40) == 0) begin
        rb[k] = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int got;
    int last_g;
    logic        tie_a [4];
    logic [63:0] tie_d [4];
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    ra = 2'b00; rb = 2'b00; rdy = 2'b11;
    for (int k = 0; k < 2; k++) begin
      da[k] = 64'd0;
      db[k] = 64'd0;
      model_reset(k);
    end
    @(negedge clk);
    repeat (3) tick();
    chk_all_zero("reset_state", 0);
    chk_all_zero("reset_state", 1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("idle_quiet", 0, ov[0] | ga[0] | gb[0], 1'b0);
    end

    // Single A request
    ra[0] = 1'b1;
    da[0] = 64'h0123_4567_89AB_CDEF;
    tick();
    chk1("single_gnt_a", 0, ga[0], 1'b1);
    chk1("single_sel", 0, sl[0], 1'b1);
    chk1("single_valid", 0, ov[0], 1'b1);
    chk64("single_data", 0, od[0], 64'h0123_4567_89AB_CDEF);
    da[0] = 64'h1111_2222_3333_4444;
    tick();
    chk1("single_valid_drop", 0, ov[0], 1'b0);
    n = 1;
    while (n < 20 && !ga[0]) begin
      tick();
      n++;
    end
    chk64("single_regrant_gap", 0, 64'(n), 64'd6);
    ra[0] = 1'b0;
    repeat (8) tick();

    // Tie right after reset: A first, then alternate
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tie_a[0] = 1'b1; tie_a[1] = 1'b0; tie_a[2] = 1'b1; tie_a[3] = 1'b0;
    tie_d[0] = 64'hAAAA_0000_0000_0000; tie_d[1] = 64'hBBBB_0000_0000_0000;
    tie_d[2] = 64'hAAAA_0000_0000_0001; tie_d[3] = 64'hBBBB_0000_0000_0001;
    ra[0] = 1'b1; da[0] = 64'hAAAA_0000_0000_0000;
    rb[0] = 1'b1; db[0] = 64'hBBBB_0000_0000_0000;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (ga[0] || gb[0]) begin
        chk1("tie_gnt_a", 0, ga[0], tie_a[got]);
        chk1("tie_sel", 0, sl[0], tie_a[got]);
        chk64("tie_data", 0, od[0], tie_d[got]);
        got++;
        if (ga[0]) da[0] = da[0] + 64'd1;
        if (gb[0]) db[0] = db[0] + 64'd1;
      end
    end
    chk64("tie_rounds", 0, 64'(got), 64'd4);
    ra[0] = 1'b0;
    rb[0] = 1'b0;
    repeat (8) tick();

    // Backpressure on a B word
    rb[0] = 1'b1;
    db[0] = 64'hFFFF_0000_FFFF_0000;
    rdy[0] = 1'b0;
    tick();
    chk1("bp_gnt_b", 0, gb[0], 1'b1);
    chk1("bp_sel", 0, sl[0], 1'b0);
    chk64("bp_data", 0, od[0], 64'hFFFF_0000_FFFF_0000);
    rb[0] = 1'b0;
    db[0] = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk1("bp_valid_held", 0, ov[0], 1'b1);
      chk64("bp_data_held", 0, od[0], 64'hFFFF_0000_FFFF_0000);
    end
    rdy[0] = 1'b1;
    tick();
    chk1("bp_done", 0, ov[0], 1'b0);

    // Request arriving in the hold interval waits for it to expire
    rb[0] = 1'b1;
    db[0] = 64'hCAFE_F00D_0000_0001;
    n = 0;
    while (n < 20 && !gb[0]) begin
      tick();
      n++;
    end
    chk64("hold_req_gap", 0, 64'(n), 64'd5);
    chk64("hold_req_data", 0, od[0], 64'hCAFE_F00D_0000_0001);
    rb[0] = 1'b0;

    // Asynchronous reset while a word is waiting
    rb[0] = 1'b1;
    db[0] = 64'h7777_8888_9999_AAAA;
    rdy[0] = 1'b0;
    n = 0;
    while (n < 20 && !gb[0]) begin
      tick();
      n++;
    end
    rb[0] = 1'b0;
    tick();
    chk1("mid_send_valid", 0, ov[0], 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk_all_zero("async_reset", 0);
    chk_all_zero("async_reset", 1);
    tick();
    rst_n = 1'b1;
    rdy[0] = 1'b1;

    // HOLD_CYCLES=0 instance: one word every two cycles
    ra[1] = 1'b1;
    da[1] = 64'h5;
    got = 0;
    last_g = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ga[1]) begin
        if (last_g >= 0) chk64("nohold_spacing", 1, 64'(c - last_g), 64'd2);
        last_g = c;
        got++;
        da[1] = da[1] + 64'd1;
      end
    end
    chk64("nohold_count", 1, 64'(got), 64'd10);
    ra[1] = 1'b0;
    repeat (4) tick();

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
